// File: rtl/glb_arbiter.sv
// glb_arbiter: round-robin arbiter with burst lock sharing one GLB SRAM port among DMA, token read and psum write-back.
module glb_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req_valid,
    input  logic [2:0]              req_we,
    input  logic [2:0]              req_lock,
    input  logic [3*ADDR_WIDTH-1:0] req_addr,
    input  logic [3*DATA_WIDTH-1:0] req_wdata,
    output logic [2:0]              req_ready,
    output logic [2:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    sram_ceb,
    output logic                    sram_web,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata,
    output logic [15:0]             conflict_cnt
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_next;
    logic [1:0] rr_ptr, rr_next, owner, owner_next, c0, c1, c2, gnt_idx;
    logic [7:0] burst_cnt, cnt_next, cnt_new;
    logic       own_hold, xfer, conflict;
    logic       tag1_v, tag2_v;
    logic [1:0] tag1_idx, tag2_idx;

    assign c0 = rr_ptr;
    assign c1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    assign c2 = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
    // an owner that drops valid releases the lock in that same cycle
    assign own_hold = (state == LOCKED) && req_valid[owner];
    assign gnt_idx  = own_hold ? owner : req_valid[c0] ? c0 : req_valid[c1] ? c1 : c2;
    assign xfer     = ~rst && |req_valid;
    assign req_ready = xfer ? 3'b001 << gnt_idx : 3'b000;
    assign conflict = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) | (req_valid[1] & req_valid[2]);
    assign cnt_new  = own_hold ? burst_cnt + 8'd1 : 8'd1;

    always_comb begin
        state_next = state;
        owner_next = owner;
        cnt_next   = burst_cnt;
        rr_next    = rr_ptr;
        if (xfer) begin
            rr_next    = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            state_next = (req_lock[gnt_idx] && cnt_new < 8'(BURST_MAX)) ? LOCKED : IDLE;
            owner_next = gnt_idx;
            cnt_next   = cnt_new;
        end else begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 2'd0;
            burst_cnt    <= 8'd0;
            rr_ptr       <= 2'd0;
            sram_ceb     <= 1'b1;
            sram_web     <= 1'b1;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            tag1_v       <= 1'b0;
            tag1_idx     <= 2'd0;
            tag2_v       <= 1'b0;
            tag2_idx     <= 2'd0;
            conflict_cnt <= 16'd0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            burst_cnt <= cnt_next;
            rr_ptr    <= rr_next;
            sram_ceb  <= ~xfer;
            sram_web  <= ~(xfer && req_we[gnt_idx]);
            if (xfer) begin
                sram_addr  <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                sram_wdata <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            tag1_v   <= xfer && !req_we[gnt_idx];
            tag1_idx <= gnt_idx;
            tag2_v   <= tag1_v;
            tag2_idx <= tag1_idx;
            if (conflict && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign rsp_valid = tag2_v ? 3'b001 << tag2_idx : 3'b000;
    assign rsp_rdata = sram_rdata;
endmodule

// File: tb/tb_glb_arbiter.sv
// tb_glb_arbiter: directed tests of grant order, locking, SRAM command timing, read return and conflict counter.
module tb_glb_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid, req_we, req_lock, req_ready, rsp_valid;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, sram_wdata, sram_rdata;
    logic          sram_ceb, sram_web;
    logic [AW-1:0] sram_addr;
    logic [15:0]   conflict_cnt;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int checks = 0;
    int failures = 0;

    glb_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // SRAM macro model: one-cycle read latency
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_addr] <= sram_wdata;
            else sram_rdata <= mem[sram_addr];
        end
    end

    task automatic idle_inputs();
        req_valid = 3'b000;
        req_we    = 3'b000;
        req_lock  = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        req_valid = 3'b111;
        step();
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        checks++;
        if (rsp_valid !== 3'b000 || sram_ceb !== 1'b1 || sram_web !== 1'b1) begin
            failures++; $display("FAIL reset_ctrl got rsp=%b ceb=%b web=%b exp 000 1 1", rsp_valid, sram_ceb, sram_web);
        end
        checks++;
        if (sram_addr !== '0 || sram_wdata !== '0 || conflict_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_vals got addr=%h wdata=%h cnt=%h exp 0", sram_addr, sram_wdata, conflict_cnt);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        mem[5] = 32'hDEADBEEF;
        do_reset();
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 14'd5;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin failures++; $display("FAIL read_ready got=%b exp=010", req_ready); end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (sram_ceb !== 1'b0 || sram_web !== 1'b1 || sram_addr !== 14'd5) begin
            failures++; $display("FAIL read_cmd got ceb=%b web=%b addr=%0d exp 0 1 5", sram_ceb, sram_web, sram_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b010 || rsp_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL read_rsp got v=%b d=%h exp 010 deadbeef", rsp_valid, rsp_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b000) begin failures++; $display("FAIL read_rsp_once got=%b exp=000", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid = 3'b111;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_g[i]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp_g[i]); end
            step();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'd6) begin failures++; $display("FAIL rr_conflict got=%0d exp=6", conflict_cnt); end
    endtask

    task automatic test_lock_burst();
        logic [2:0] exp_g;
        int errs = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req_valid = 3'b111;
            req_lock  = 3'b001;
            exp_g = (i < 16) ? 3'b001 : (i == 16) ? 3'b010 : (i == 17) ? 3'b100 : 3'b001;
            @(negedge clk);
            if (req_ready !== exp_g) begin
                errs++;
                $display("FAIL lock_grant%0d got=%b exp=%b", i, req_ready, exp_g);
            end
            step();
        end
        checks++;
        if (errs != 0) failures++;
        idle_inputs();
    endtask

    task automatic test_owner_drop();
        do_reset();
        req_valid = 3'b010;
        req_lock  = 3'b010;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin failures++; $display("FAIL drop_first got=%b exp=010", req_ready); end
        step();
        req_valid = 3'b101;
        req_lock  = 3'b000;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin failures++; $display("FAIL drop_release got=%b exp=100", req_ready); end
        step();
        idle_inputs();
    endtask

    task automatic test_raw();
        do_reset();
        req_valid = 3'b100;
        req_we    = 3'b100;
        req_addr[2*AW +: AW]  = 14'd192;
        req_wdata[2*DW +: DW] = 32'h12345678;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin failures++; $display("FAIL raw_wr_ready got=%b exp=100", req_ready); end
        step();
        idle_inputs();
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 14'd192;
        @(negedge clk);
        checks++;
        if (sram_ceb !== 1'b0 || sram_web !== 1'b0 || sram_wdata !== 32'h12345678) begin
            failures++; $display("FAIL raw_wr_cmd got ceb=%b web=%b wd=%h exp 0 0 12345678", sram_ceb, sram_web, sram_wdata);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b000) begin failures++; $display("FAIL raw_no_wr_rsp got=%b exp=000", rsp_valid); end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b010 || rsp_rdata !== 32'h12345678) begin
            failures++; $display("FAIL raw_rsp got v=%b d=%h exp 010 12345678", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        int errs = 0;
        do_reset();
        req_valid = 3'b001;
        req_addr[0 +: AW] = 14'd5;
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sram_ceb !== 1'b1 || sram_web !== 1'b1 || sram_addr !== '0) begin
            failures++; $display("FAIL rstmid_cmd got ceb=%b web=%b addr=%0d exp 1 1 0", sram_ceb, sram_web, sram_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 3'b000) begin errs++; $display("FAIL rstmid_rsp%0d got=%b exp=000", i, rsp_valid); end
            step();
        end
        checks++;
        if (errs != 0) failures++;
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 3'b011;
        for (int i = 0; i < 70000; i++) step();
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_value got=%h exp=ffff", conflict_cnt); end
        step();
        step();
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        sram_rdata = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_owner_drop();
        test_raw();
        test_reset_mid_read();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/glb_arbiter.md
# glb_arbiter

Single-port GLB access arbiter. Shares the one GLB SRAM port among three requesters: DMA fill (index 0), token engine read (index 1) and token engine psum write-back (index 2). Serialises their accepted requests into a registered SRAM command stream and routes read data back to the issuing requester with fixed latency. It sits between the token engine/DMA and the GLB macro and replaces the direct token-engine-to-GLB connection.

## Interface

Parameters:
- ADDR_WIDTH, 14, GLB word address width
- DATA_WIDTH, 32, GLB word width
- BURST_MAX, 16, maximum consecutive grants under lock (range 1..255)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  3  request valid, one bit per requester
- req_we  in  3  1 = write, 0 = read, per requester
- req_lock  in  3  keep grant for the next beat (burst)
- req_addr  in  3*ADDR_WIDTH  requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  3*DATA_WIDTH  write data, packed the same way
- req_ready  out  3  grant/accept; at most one bit high
- rsp_valid  out  3  read data valid, one-hot
- rsp_rdata  out  DATA_WIDTH  read data (shared bus)
- sram_ceb  out  1  chip enable, active-low
- sram_web  out  1  write enable, active-low (0 = write)
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after the command cycle
- conflict_cnt  out  16  cycles with two or more requests valid, saturating

## Operation

- Handshake: a beat transfers in a cycle where req_valid[i] and req_ready[i] are both high. req_ready is combinational from req_valid, rr_ptr and lock state. req_ready[i] is never high without req_valid[i].
- Round-robin: rr_ptr (2 bits, values 0..2) names the highest-priority index. The search order is rr_ptr, rr_ptr+1, rr_ptr+2, mod 3. On a transfer by i, rr_ptr becomes (i+1) mod 3.
- Lock states:
  - IDLE: normal round-robin.
  - LOCKED: entered when the transferring beat has req_lock[i]=1. Stores owner=i and sets burst_cnt=1.
  - While LOCKED, only the owner may be granted. Each owner transfer increments burst_cnt.
  - LOCKED -> IDLE when: an owner beat transfers with req_lock=0; or burst_cnt reaches BURST_MAX on a transfer (forced release; rr_ptr advances past owner); or the owner drops req_valid for a cycle (release in that cycle, others arbitrate in the same cycle).
- Command stage: on transfer, register sram_ceb=0, sram_web=~req_we[i], sram_addr, sram_wdata for exactly one cycle. With no transfer: sram_ceb=1, sram_web=1; addr/wdata hold their previous values.
- Response tag: for a read, a 2-stage pipeline carries {valid, idx}. rsp_valid[idx] goes high during N+2 with rsp_rdata = sram_rdata (passthrough). No rsp_valid for writes.
- conflict_cnt increments each cycle with popcount(req_valid) >= 2. It saturates at 0xFFFF and clears only on rst.
- Read-after-write ordering is preserved: commands issue in transfer order, one per cycle.

## Timing

- Throughput: one transfer per cycle, no bubbles between requesters.
- Latency:
  - transfer at cycle N;
  - SRAM command visible during N+1;
  - read data plus rsp_valid during N+2.
- Reset values: req_ready=0 while rst is high, rsp_valid=0, rsp_rdata = sram_rdata passthrough, sram_ceb=1, sram_web=1, sram_addr=0, sram_wdata=0, conflict_cnt=0. Internal reset values: rr_ptr=0, state IDLE, tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped. No rsp_valid appears after rst is sampled high.
- Requesters must hold req_addr/req_we/req_wdata stable while req_valid is high and ready is low.

## Test plan

- Single read:
  - Stimulus: mem[5]=32'hDEADBEEF; req_valid=3'b010, addr 5, we=0 at cycle N.
  - Response: req_ready=3'b010 at N; ceb=0, web=1, addr=5 at N+1; rsp_valid=3'b010 and rsp_rdata=DEADBEEF at N+2.
- Round-robin:
  - Stimulus: all three requesters valid continuously for 6 beats from reset.
  - Response: grant order 0,1,2,0,1,2; conflict_cnt=6.
- Lock burst:
  - Stimulus: requester 0 with lock=1 for 20 beats; requesters 1 and 2 valid throughout.
  - Response: 16 consecutive grants to 0, then 1, then 2, then 0 resumes.
- RAW ordering:
  - Stimulus: requester 2 writes 32'h12345678 to addr 192 at N; requester 1 reads addr 192 at N+1.
  - Response: rsp_rdata=12345678 at N+3.
- Reset mid-read:
  - Stimulus: read transfer at N; rst=1 at N+1.
  - Response: rsp_valid stays 0; ceb=1, web=1, addr=0 at the reset edge.
- Saturation:
  - Stimulus: two requesters valid for 70000 cycles.
  - Response: conflict_cnt=16'hFFFF and holds.
